// File: rtl/vram_pkg.sv
// Shared types for the nametable RAM: mirroring modes, control states and
// page sizing.
package vram_pkg;

  localparam int PAGE_WORDS = 1024;

  typedef enum logic [2:0] {
    MM_HORIZONTAL = 3'd0,
    MM_VERTICAL   = 3'd1,
    MM_SINGLE_A   = 3'd2,
    MM_SINGLE_B   = 3'd3,
    MM_FOUR       = 3'd4
  } mirror_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE_RST = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_RUN      = 2'd2
  } nt_state_e;

  // A single-page build still needs a 1-bit page signal.
  function automatic int page_bits(input int pages);
    return (pages > 1) ? $clog2(pages) : 1;
  endfunction

endpackage

// File: rtl/nt_mirror_map.sv
// Maps a logical nametable (addr[11:10]) to a physical page for the current
// mirroring mode. Purely combinational.
module nt_mirror_map
  import vram_pkg::*;
#(
  parameter int PAGES = 2,
  localparam int PW = page_bits(PAGES)
) (
  input  logic [2:0]    mirror_mode,
  input  logic [1:0]    table_sel,
  output logic [PW-1:0] page
);

  logic [1:0] raw_page;

  always_comb begin
    raw_page = {1'b0, table_sel[1]};
    case (mirror_mode)
      MM_HORIZONTAL: raw_page = {1'b0, table_sel[1]};
      MM_VERTICAL:   raw_page = {1'b0, table_sel[0]};
      MM_SINGLE_A:   raw_page = 2'd0;
      MM_SINGLE_B:   raw_page = 2'd1;
      MM_FOUR:       raw_page = table_sel;
      default:       raw_page = {1'b0, table_sel[1]};
    endcase
    // Folding into the populated pages keeps every access inside the array.
    page = PW'(32'(raw_page) % PAGES);
  end

endmodule

// File: rtl/nametable_ram.sv
// Mirrored nametable RAM with a post-reset zero-fill sequence.
//   state       | meaning
//   ST_IDLE_RST | reset state, one cycle, picks CLEAR or RUN
//   ST_CLEAR    | ready=0, zero-fills one physical word per cycle
//   ST_RUN      | ready=1, serving read/write requests
module nametable_ram
  import vram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int PAGES          = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mirror_mode,
  input  logic              req,
  input  logic              we,
  input  logic [11:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int DEPTH = PAGES * PAGE_WORDS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PW    = page_bits(PAGES);

  nt_state_e         state, state_nxt;
  logic [CW-1:0]     clr_cnt;
  logic              clr_last;
  logic [PW-1:0]     page;
  logic [AW-1:0]     phys_addr;
  logic              mem_we, rd_en;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  nt_mirror_map #(.PAGES(PAGES)) u_map (
    .mirror_mode (mirror_mode),
    .table_sel   (addr[11:10]),
    .page        (page)
  );

  assign phys_addr = AW'({page, addr[9:0]});
  assign clr_last  = (clr_cnt == CW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE_RST;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE_RST: state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      ST_CLEAR:    if (clr_last) state_nxt = ST_RUN;
      ST_RUN:      state_nxt = ST_RUN;
      default:     state_nxt = ST_IDLE_RST;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    mem_we    = 1'b0;
    rd_en     = 1'b0;
    mem_addr  = phys_addr;
    mem_wdata = wdata;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt[AW-1:0];
        mem_wdata = '0;
      end
      ST_RUN: begin
        ready  = 1'b1;
        mem_we = req & we;
        rd_en  = req & ~we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // Storage has no reset; only the CLEAR walk zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= mem[mem_addr];
    end
  end

endmodule

// File: tb/tb_nametable_ram.sv
// Directed bench for nametable_ram: a 2-page cleared instance and a 4-page
// instance without clear, read results checked through scoreboard queues.
module tb_nametable_ram;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  mm2 = '0, mm4 = '0;
  logic        req2 = 1'b0, we2 = 1'b0, req4 = 1'b0, we4 = 1'b0;
  logic [11:0] addr2 = '0, addr4 = '0;
  logic [7:0]  wdata2 = '0, wdata4 = '0;
  logic        ready2, ready4, rvalid2, rvalid4;
  logic [7:0]  rdata2, rdata4;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  sb_t q2[$];
  sb_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nametable_ram #(.DATA_W(8), .PAGES(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst), .mirror_mode(mm2), .req(req2), .we(we2),
    .addr(addr2), .wdata(wdata2), .ready(ready2), .rdata(rdata2), .rvalid(rvalid2)
  );

  nametable_ram #(.DATA_W(8), .PAGES(4), .CLEAR_ON_RESET(0)) dut4 (
    .clk(clk), .rst(rst), .mirror_mode(mm4), .req(req4), .we(we4),
    .addr(addr4), .wdata(wdata4), .ready(ready4), .rdata(rdata4), .rvalid(rvalid4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every rvalid must match the oldest outstanding read, on the expected cycle.
  always @(negedge clk) begin
    if (rvalid2 === 1'b1) begin
      chk("dut2_rvalid_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        sb_t e;
        e = q2.pop_front();
        chk("dut2_rdata", 32'(rdata2), 32'(e.data));
        chk("dut2_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (rvalid4 === 1'b1) begin
      chk("dut4_rvalid_expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        sb_t e;
        e = q4.pop_front();
        chk("dut4_rdata", 32'(rdata4), 32'(e.data));
        chk("dut4_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drives one request for one cycle, starting and ending at a falling edge.
  task automatic issue2(input logic [2:0] mm, input logic w, input logic [11:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    mm2 = mm; req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    if (!w) q2.push_back('{data: exp, cyc: cyc + 1});
    @(negedge clk);
    req2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic issue4(input logic [2:0] mm, input logic w, input logic [11:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    mm4 = mm; req4 = 1'b1; we4 = w; addr4 = a; wdata4 = d;
    if (!w) q4.push_back('{data: exp, cyc: cyc + 1});
    @(negedge clk);
    req4 = 1'b0; we4 = 1'b0;
  endtask

  // Called right after reset release; counts CLEAR cycles once IDLE_RST exits.
  task automatic measure_clear(output int n);
    @(posedge clk); #1;
    n = 0;
    while (!ready2 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    req2 = 1'b0; we2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready2), 32'd0);
    chk("rst_rvalid", 32'(rvalid2), 32'd0);
    chk("rst_rdata", 32'(rdata2), 32'd0);
    chk("rst_ready4", 32'(ready4), 32'd0);
    rst = 1'b1;
    measure_clear(n);
    chk("clear_cycles", 32'(n), 32'd2048);
    chk("ready4_no_clear", 32'(ready4), 32'd1);

    issue2(3'd4, 1'b0, 12'h000, 8'h00, 8'h00);
    issue2(3'd4, 1'b0, 12'h7FF, 8'h00, 8'h00);
    issue2(3'd0, 1'b0, 12'hC00, 8'h00, 8'h00);

    // Vertical aliasing and rdata hold across a write.
    issue2(3'd1, 1'b1, 12'h000, 8'h5A, 8'h00);
    issue2(3'd1, 1'b0, 12'h400, 8'h00, 8'h00);
    issue2(3'd1, 1'b0, 12'h800, 8'h00, 8'h5A);
    issue2(3'd1, 1'b1, 12'h001, 8'h11, 8'h00);
    chk("write_no_rvalid", 32'(rvalid2), 32'd0);
    chk("write_rdata_hold", 32'(rdata2), 32'h5A);
    @(negedge clk);
    chk("idle_rdata_hold", 32'(rdata2), 32'h5A);

    issue2(3'd0, 1'b1, 12'h400, 8'hA5, 8'h00);
    issue2(3'd0, 1'b1, 12'hC00, 8'h3C, 8'h00);
    issue2(3'd0, 1'b0, 12'h000, 8'h00, 8'hA5);
    issue2(3'd0, 1'b0, 12'h800, 8'h00, 8'h3C);

    issue2(3'd4, 1'b1, 12'hC00, 8'h99, 8'h00);
    issue2(3'd4, 1'b0, 12'h400, 8'h00, 8'h99);

    issue2(3'd4, 1'b1, 12'h123, 8'h77, 8'h00);
    issue2(3'd4, 1'b0, 12'h123, 8'h00, 8'h77);

    for (int i = 0; i < 8; i++) issue2(3'd4, 1'b1, 12'h010 + 12'(i), 8'h80 + 8'(i), 8'h00);
    for (int i = 0; i < 8; i++) issue2(3'd4, 1'b0, 12'h010 + 12'(i), 8'h00, 8'h80 + 8'(i));

    // Mode changes every cycle, each applying to its own access.
    issue2(3'd4, 1'b1, 12'h006, 8'h61, 8'h00);
    issue2(3'd4, 1'b1, 12'h406, 8'h62, 8'h00);
    issue2(3'd1, 1'b0, 12'h806, 8'h00, 8'h61);
    issue2(3'd0, 1'b0, 12'h806, 8'h00, 8'h62);
    issue2(3'd2, 1'b0, 12'hC06, 8'h00, 8'h61);
    issue2(3'd3, 1'b0, 12'h006, 8'h00, 8'h62);
    issue2(3'd5, 1'b0, 12'h406, 8'h00, 8'h61);
    issue2(3'd4, 1'b0, 12'hC06, 8'h00, 8'h62);

    issue4(3'd4, 1'b1, 12'h000, 8'h10, 8'h00);
    issue4(3'd4, 1'b1, 12'h400, 8'h20, 8'h00);
    issue4(3'd4, 1'b1, 12'h800, 8'h30, 8'h00);
    issue4(3'd4, 1'b1, 12'hC00, 8'h40, 8'h00);
    issue4(3'd4, 1'b0, 12'h000, 8'h00, 8'h10);
    issue4(3'd4, 1'b0, 12'h400, 8'h00, 8'h20);
    issue4(3'd4, 1'b0, 12'h800, 8'h00, 8'h30);
    issue4(3'd4, 1'b0, 12'hC00, 8'h00, 8'h40);
    issue4(3'd3, 1'b0, 12'h000, 8'h00, 8'h20);
    repeat (2) @(negedge clk);

    // Reset during a read's result cycle suppresses the pulse.
    mm2 = 3'd4; req2 = 1'b1; we2 = 1'b0; addr2 = 12'h010;
    @(posedge clk); #1;
    req2 = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_rvalid", 32'(rvalid2), 32'd0);
    chk("abort_rdata", 32'(rdata2), 32'd0);
    chk("abort_ready", 32'(ready2), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset at clear count 100 with writes requested throughout the clear.
    req2 = 1'b1; we2 = 1'b1; wdata2 = 8'hFF; addr2 = 12'h020;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midclear_ready", 32'(ready2), 32'd0);
    rst = 1'b1;
    measure_clear(n);
    chk("restart_clear_cycles", 32'(n), 32'd2048);

    for (int i = 0; i < 2048; i++) issue2(3'd4, 1'b0, 12'(i), 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nametable_ram.md
NAMETABLE_RAM -- requirements
Module: nametable_ram

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The module SHALL have parameter PAGES, default 2, meaning the number of physical 1024-word pages (legal 1..4).
REQ-003 The module SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill all pages after reset before accepting requests.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 mirror_mode  input  3  mode codes: 0 horizontal, 1 vertical, 2 single-screen A, 3 single-screen B, 4 four-screen, 5-7 reserved.
REQ-008 req  input  1  access request, qualified by ready.
REQ-009 we  input  1  1 = write, 0 = read; sampled with req.
REQ-010 addr  input  12  nametable offset ($2000-$2FFF region minus base): bits [11:10] select the logical table, bits [9:0] select the word.
REQ-011 wdata  input  DATA_W  write data.
REQ-012 ready  output  1  high when requests are accepted.
REQ-013 rdata  output  DATA_W  registered read data.
REQ-014 rvalid  output  1  one-cycle pulse marking new rdata.

Function
REQ-015 A request is accepted on a rising edge where req=1 and ready=1; when ready=0, req is ignored with no memory or output effect.
REQ-016 The physical address SHALL be page*1024 + addr[9:0], where page is derived from mirror_mode as follows:
- horizontal: addr[11].
- vertical: addr[10].
- single-A: 0.
- single-B: 1 mod PAGES.
- four-screen: addr[11:10] mod PAGES.
- reserved: treated as horizontal.
REQ-017 The page value SHALL be reduced mod PAGES in all modes, so that no access falls outside the physical array.
REQ-018 mirror_mode SHALL be sampled on the same edge as the request, with no pipeline delay; a change applies to the very next accepted access.
REQ-019 An accepted write SHALL update the word at the edge; rvalid stays 0 and rdata holds its value.
REQ-020 An accepted read SHALL present data on rdata with rvalid=1 exactly one cycle after acceptance.
REQ-021 rdata SHALL hold its last value until the next accepted read.
REQ-022 Back-to-back reads SHALL give one result per cycle, in order.
REQ-023 Read-after-write to the same physical word on consecutive cycles SHALL return the new data.
REQ-024 Two logical addresses aliased by mirroring SHALL read and write the same physical word.
REQ-025 The control FSM SHALL have three states:
- CLEAR: ready=0; a counter writes 0 to physical words 0..PAGES*1024-1, one per cycle; after the last word, go to RUN.
- RUN: ready=1.
- IDLE_RST: the reset state; next state is CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-026 The clear SHALL take exactly PAGES*1024 cycles; ready rises on the cycle after the final zero write.
REQ-027 The clear counter SHALL be sized clog2(PAGES*1024)+1 bits, so that terminal detection never wraps.

Reset
REQ-028 Asserting rst SHALL asynchronously force the following: FSM=IDLE_RST, ready=0, rvalid=0, rdata=0, clear counter=0.
REQ-029 Memory contents SHALL NOT be reset directly; only the CLEAR sequence zeroes them.
REQ-030 Reset asserted mid-clear or mid-read SHALL abort the operation; no rvalid pulse is produced for the aborted read, and the clear restarts from word 0 after deassertion.

Structure
REQ-031 A shared package vram_pkg SHALL hold the following:
- the mirror_mode enum type (codes per REQ-007);
- PAGE_WORDS=1024;
- the FSM state enum.
REQ-032 The page-select logic SHALL be a combinational sub-module nt_mirror_map (inputs mirror_mode, addr[11:10]; output page), parametrised by PAGES.
REQ-033 The storage array SHALL be a single inferred synchronous-write, registered-read RAM of PAGES*1024 x DATA_W.

Verification
REQ-034 Reset release with PAGES=2, CLEAR_ON_RESET=1 -> ready low for exactly 2048 cycles; afterwards, a read of any address returns 0x00.
REQ-035 Vertical mode: write 0x5A at addr 0x000, then read 0x800 -> rdata=0x5A with rvalid one cycle after acceptance; a read of 0x400 does not return 0x5A.
REQ-036 Horizontal mode: write 0xA5 at 0x400, then read 0x000 -> 0xA5; a read of 0x800 returns the other page.
REQ-037 Four-screen mode with PAGES=4: write distinct values to 0x000/0x400/0x800/0xC00 -> all four read back distinct; with PAGES=2, 0xC00 aliases 0x400.
REQ-038 Pulse rst low at clear count 100, then release -> ready low for a full 2048 cycles from release; no rvalid is produced.
REQ-039 req held high during CLEAR with we=1, wdata=0xFF -> after clear, all words read 0x00.
